hazard_stall_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core: decides each cycle whether the pipeline runs, stalls ID (bubble into EX), or freezes completely, and issues IF/ID flushes for taken branches and jumps. It sits beside the forwarding unit: it covers the hazards forwarding cannot resolve (load-use, ID-stage branch operands, multi-cycle mul/div results, data-memory wait) and drives the PC and pipeline-register enables.

---
 rtl/hazard_stall_controller.sv | 179 +++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// hazard_stall_controller
//
// Pipeline sequencing controller for the 5-stage MIPS core. Every cycle it
// picks one of four causes (RUN, HAZARD, MULDIV, FREEZE), in strict priority
// FREEZE > MULDIV > HAZARD > RUN. From that cause it drives the PC and
// pipeline-register enables, the ID/EX bubble and the IF/ID flush. It handles
// the hazards that forwarding cannot resolve: load-use, branch operands
// compared in ID, pending mul/div results, and data-memory wait states.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   ID_rs, ID_rt, ID_usesRt    sources of the instruction in ID
//   ID_isBranch                ID compares operands (branch resolved in ID)
//   ID_isMulDiv, ID_readsHiLo  ID is mult/div, or ID is mfhi/mflo
//   ID_EX_*                    control and destinations of the EX instruction
//   EX_MEM_memRead, EX_MEM_rt  load currently in MEM
//   branchTaken, jump          ID-stage redirect requests
//   memReady                   data memory ready (0 freezes the pipeline)
//   PC_write, IF_ID_write      front-end enables
//   IF_ID_flush                zero IF/ID on this edge
//   ID_EX_bubble               load a NOP into ID/EX on this edge
//   EX_MEM_write, MEM_WB_write back-end enables
//   mulDivBusy                 mul/div unit still producing HI/LO
//   stallCause                 0 RUN, 1 HAZARD, 2 MULDIV, 3 FREEZE
//   stallCount                 saturating count of non-RUN cycles
// -----------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int unsigned MULDIV_CYCLES = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_usesRt,
  input  logic        ID_isBranch,
  input  logic        ID_isMulDiv,
  input  logic        ID_readsHiLo,
  input  logic        ID_EX_regWrite,
  input  logic        ID_EX_memRead,
  input  logic        ID_EX_isMulDiv,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  ID_EX_rt,
  input  logic        EX_MEM_memRead,
  input  logic [4:0]  EX_MEM_rt,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        memReady,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_write,
  output logic        MEM_WB_write,
  output logic        mulDivBusy,
  output logic [1:0]  stallCause,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {
    CAUSE_RUN    = 2'd0,
    CAUSE_HAZARD = 2'd1,
    CAUSE_MULDIV = 2'd2,
    CAUSE_FREEZE = 2'd3
  } cause_e;

  localparam logic [3:0] LP_BUSY_LOAD = 4'(MULDIV_CYCLES);

  logic [3:0]  r_busy_cnt;
  logic        r_pending_flush;
  logic [15:0] r_stall_count;

  cause_e      w_cause;
  logic        w_rs_valid;
  logic        w_rt_valid;
  logic        w_hit_ex_rt;
  logic        w_hit_ex_rd;
  logic        w_hit_mem_rt;
  logic        w_load_use;
  logic        w_branch_alu;
  logic        w_branch_load;
  logic        w_muldiv_hazard;
  logic        w_data_hazard;

  // $0 is hard-wired zero, so it never creates a dependency. rt is only a
  // source when the instruction actually reads it (e.g. not for lw/addi).
  assign w_rs_valid   = (ID_rs != 5'd0);
  assign w_rt_valid   = ID_usesRt && (ID_rt != 5'd0);

  assign w_hit_ex_rt  = (w_rs_valid && (ID_rs == ID_EX_rt))  || (w_rt_valid && (ID_rt == ID_EX_rt));
  assign w_hit_ex_rd  = (w_rs_valid && (ID_rs == ID_EX_rd))  || (w_rt_valid && (ID_rt == ID_EX_rd));
  assign w_hit_mem_rt = (w_rs_valid && (ID_rs == EX_MEM_rt)) || (w_rt_valid && (ID_rt == EX_MEM_rt));

  assign w_load_use    = ID_EX_memRead && w_hit_ex_rt;
  // ALU results can reach EX consumers by forwarding, but a branch compares
  // in ID, so it must wait one cycle. A load in EX is covered by load-use.
  assign w_branch_alu  = ID_isBranch && ID_EX_regWrite && !ID_EX_memRead && w_hit_ex_rd;
  // Load data only appears at the end of MEM: a branch waits a second cycle.
  assign w_branch_load = ID_isBranch && EX_MEM_memRead && w_hit_mem_rt;
  assign w_data_hazard = w_load_use || w_branch_alu || w_branch_load;

  // HI/LO is unavailable while the unit counts down, and also in the cycle
  // the mul/div occupies EX, before the counter has been loaded.
  assign w_muldiv_hazard = (ID_isMulDiv || ID_readsHiLo) &&
                           ((r_busy_cnt != 4'd0) || ID_EX_isMulDiv);

  always_comb begin
    // NOTE: every combinational output gets a default first, so that no path
    // leaves a signal unassigned and no latch is inferred.
    w_cause = CAUSE_RUN;
    if (!memReady)            w_cause = CAUSE_FREEZE;
    else if (w_muldiv_hazard) w_cause = CAUSE_MULDIV;
    else if (w_data_hazard)   w_cause = CAUSE_HAZARD;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = branchTaken || jump || r_pending_flush;
    ID_EX_bubble = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    stallCause   = w_cause;

    if (reset) begin
      // Reset flushes the front end and pushes NOPs down the back end.
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      stallCause   = CAUSE_RUN;
    end else begin
      unique case (w_cause)
        CAUSE_FREEZE: begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          IF_ID_flush  = 1'b0;
          EX_MEM_write = 1'b0;
          MEM_WB_write = 1'b0;
        end
        CAUSE_MULDIV, CAUSE_HAZARD: begin
          // Redirects are ignored: the branch operands are not valid yet and
          // the branch is re-evaluated once the stall clears.
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          IF_ID_flush  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous
  // reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt      <= 4'd0;
      r_pending_flush <= 1'b0;
      r_stall_count   <= 16'd0;
    end else begin
      // A frozen EX stage does not advance, so the mul/div has not issued yet.
      // The counter still runs down during a freeze: the unit keeps working.
      if (ID_EX_isMulDiv && (w_cause != CAUSE_FREEZE)) r_busy_cnt <= LP_BUSY_LOAD;
      else if (r_busy_cnt != 4'd0)                    r_busy_cnt <= r_busy_cnt - 4'd1;

      // A redirect seen while frozen is remembered and applied on the next RUN.
      if ((w_cause == CAUSE_FREEZE) && (branchTaken || jump)) r_pending_flush <= 1'b1;
      else if (w_cause == CAUSE_RUN)                          r_pending_flush <= 1'b0;

      if ((w_cause != CAUSE_RUN) && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign mulDivBusy = (r_busy_cnt != 4'd0);
  assign stallCount = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_controller
//
// Self-checking bench for hazard_stall_controller (MULDIV_CYCLES = 4).
// A table of single-cycle vectors covers the cause priority and the hazard
// detection terms. Hand-written sequences cover the multi-cycle behaviour:
// branch after load, mul/div countdown, freeze with a pending jump, counter
// saturation and reset in the middle of a mul/div.
// -----------------------------------------------------------------------------
module tb_hazard_stall_controller;

  // Input bundle; mem_wait is the inverse of memReady so that '0 means idle.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       is_branch;
    logic       is_muldiv;
    logic       reads_hilo;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       ex_is_muldiv;
    logic [4:0] ex_rd;
    logic [4:0] ex_rt;
    logic       mem_mem_read;
    logic [4:0] mem_rt;
    logic       br_taken;
    logic       jump;
    logic       mem_wait;
  } vin_t;

  typedef struct {
    string      name;
    vin_t       in;
    logic [7:0] exp;
  } vec_t;

  // Output pattern {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
  //                 EX_MEM_write, MEM_WB_write, stallCause[1:0]}
  localparam logic [7:0] O_RUN  = 8'b1100_1100;
  localparam logic [7:0] O_RUNF = 8'b1110_1100;
  localparam logic [7:0] O_HAZ  = 8'b0001_1101;
  localparam logic [7:0] O_MUL  = 8'b0001_1110;
  localparam logic [7:0] O_FRZ  = 8'b0000_0011;
  localparam logic [7:0] O_RST  = 8'b0011_1100;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs, ID_rt, ID_EX_rd, ID_EX_rt, EX_MEM_rt;
  logic        ID_usesRt, ID_isBranch, ID_isMulDiv, ID_readsHiLo;
  logic        ID_EX_regWrite, ID_EX_memRead, ID_EX_isMulDiv, EX_MEM_memRead;
  logic        branchTaken, jump, memReady;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic        EX_MEM_write, MEM_WB_write, mulDivBusy;
  logic [1:0]  stallCause;
  logic [15:0] stallCount;
  logic [7:0]  out8;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign out8 = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
                 EX_MEM_write, MEM_WB_write, stallCause};

  hazard_stall_controller #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_usesRt(ID_usesRt),
    .ID_isBranch(ID_isBranch), .ID_isMulDiv(ID_isMulDiv), .ID_readsHiLo(ID_readsHiLo),
    .ID_EX_regWrite(ID_EX_regWrite), .ID_EX_memRead(ID_EX_memRead),
    .ID_EX_isMulDiv(ID_EX_isMulDiv), .ID_EX_rd(ID_EX_rd), .ID_EX_rt(ID_EX_rt),
    .EX_MEM_memRead(EX_MEM_memRead), .EX_MEM_rt(EX_MEM_rt),
    .branchTaken(branchTaken), .jump(jump), .memReady(memReady),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .mulDivBusy(mulDivBusy), .stallCause(stallCause), .stallCount(stallCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vin_t v);
    ID_rs          = v.rs;
    ID_rt          = v.rt;
    ID_usesRt      = v.uses_rt;
    ID_isBranch    = v.is_branch;
    ID_isMulDiv    = v.is_muldiv;
    ID_readsHiLo   = v.reads_hilo;
    ID_EX_regWrite = v.ex_reg_write;
    ID_EX_memRead  = v.ex_mem_read;
    ID_EX_isMulDiv = v.ex_is_muldiv;
    ID_EX_rd       = v.ex_rd;
    ID_EX_rt       = v.ex_rt;
    EX_MEM_memRead = v.mem_mem_read;
    EX_MEM_rt      = v.mem_rt;
    branchTaken    = v.br_taken;
    jump           = v.jump;
    memReady       = ~v.mem_wait;
  endtask

  // Apply inputs on the falling edge and settle; the caller samples mid-cycle.
  task automatic cyc(input vin_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive('0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input string name, input vin_t in, input logic [7:0] exp);
    vec_t e;
    e.name = name;
    e.in   = in;
    e.exp  = exp;
    tbl.push_back(e);
  endtask

  initial begin
    vin_t v;

    // Vectors assume an idle controller (busy=0, no pending flush). Entries
    // that issue a mul/div into EX are kept last since they load the counter.
    add("idle",             '{default:'0}, O_RUN);
    add("load_use_rs",      '{default:'0, ex_mem_read:1'b1, ex_rt:5'd5, rs:5'd5}, O_HAZ);
    add("load_use_r0",      '{default:'0, ex_mem_read:1'b1, ex_rt:5'd0, rs:5'd0}, O_RUN);
    add("load_use_rt",      '{default:'0, ex_mem_read:1'b1, ex_rt:5'd7, rt:5'd7, uses_rt:1'b1}, O_HAZ);
    add("load_rt_unused",   '{default:'0, ex_mem_read:1'b1, ex_rt:5'd7, rt:5'd7}, O_RUN);
    add("load_other_reg",   '{default:'0, ex_mem_read:1'b1, ex_rt:5'd5, rs:5'd6}, O_RUN);
    add("branch_alu",       '{default:'0, is_branch:1'b1, ex_reg_write:1'b1, ex_rd:5'd9, rs:5'd9}, O_HAZ);
    add("alu_fwd_no_br",    '{default:'0, ex_reg_write:1'b1, ex_rd:5'd9, rs:5'd9}, O_RUN);
    add("branch_alu_ld_rd", '{default:'0, is_branch:1'b1, ex_reg_write:1'b1, ex_mem_read:1'b1,
                              ex_rd:5'd9, ex_rt:5'd3, rs:5'd9}, O_RUN);
    add("branch_load_mem",  '{default:'0, is_branch:1'b1, mem_mem_read:1'b1, mem_rt:5'd8, rs:5'd8}, O_HAZ);
    add("branch_ld_mem_rt", '{default:'0, is_branch:1'b1, mem_mem_read:1'b1, mem_rt:5'd4,
                              rt:5'd4, uses_rt:1'b1}, O_HAZ);
    add("mem_load_no_br",   '{default:'0, mem_mem_read:1'b1, mem_rt:5'd8, rs:5'd8}, O_RUN);
    add("branch_taken",     '{default:'0, br_taken:1'b1}, O_RUNF);
    add("jump",             '{default:'0, jump:1'b1}, O_RUNF);
    add("taken_in_hazard",  '{default:'0, br_taken:1'b1, ex_mem_read:1'b1, ex_rt:5'd5, rs:5'd5}, O_HAZ);
    add("freeze",           '{default:'0, mem_wait:1'b1}, O_FRZ);
    add("freeze_over_haz",  '{default:'0, mem_wait:1'b1, ex_mem_read:1'b1, ex_rt:5'd5, rs:5'd5}, O_FRZ);
    add("freeze_over_mul",  '{default:'0, mem_wait:1'b1, reads_hilo:1'b1, ex_is_muldiv:1'b1}, O_FRZ);
    add("muldiv_idle_unit", '{default:'0, is_muldiv:1'b1}, O_RUN);
    add("mul_over_hazard",  '{default:'0, reads_hilo:1'b1, ex_is_muldiv:1'b1,
                              ex_mem_read:1'b1, ex_rt:5'd5, rs:5'd5}, O_MUL);
    add("muldiv_back2back", '{default:'0, is_muldiv:1'b1, ex_is_muldiv:1'b1}, O_MUL);

    // ---- reset values ----
    reset = 1'b1;
    drive('0);
    @(negedge clk); #1;
    check("reset_outputs", 32'(out8), 32'(O_RST));
    @(negedge clk); #1;
    check("reset_stallcount", 32'(stallCount), 32'd0);
    check("reset_busy", 32'(mulDivBusy), 32'd0);
    reset = 1'b0;

    // ---- single-cycle table ----
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in);
      check(tbl[i].name, 32'(out8), 32'(tbl[i].exp));
    end

    // ---- branch after load: load-use cycle, then branch-load-in-MEM cycle ----
    do_reset();
    v = '{default:'0, is_branch:1'b1, rs:5'd8, br_taken:1'b1, ex_mem_read:1'b1, ex_rt:5'd8};
    cyc(v);
    check("bal_cycle1", 32'(out8), 32'(O_HAZ));
    v.ex_mem_read = 1'b0; v.ex_rt = 5'd0; v.mem_mem_read = 1'b1; v.mem_rt = 5'd8;
    cyc(v);
    check("bal_cycle2", 32'(out8), 32'(O_HAZ));
    v.mem_mem_read = 1'b0; v.mem_rt = 5'd0;
    cyc(v);
    check("bal_run_flush", 32'(out8), 32'(O_RUNF));
    check("bal_stallcount", 32'(stallCount), 32'd2);

    // ---- mult in EX, mflo arrives in ID the following cycle ----
    do_reset();
    cyc('{default:'0, ex_is_muldiv:1'b1});
    check("mul_issue_run", 32'(out8), 32'(O_RUN));
    check("mul_issue_busy", 32'(mulDivBusy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc('{default:'0, reads_hilo:1'b1});
      check($sformatf("mflo_stall%0d", k), 32'(out8), 32'(O_MUL));
      check($sformatf("mflo_busy%0d", k), 32'(mulDivBusy), 32'd1);
    end
    cyc('{default:'0, reads_hilo:1'b1});
    check("mflo_proceeds", 32'(out8), 32'(O_RUN));
    check("mflo_busy_done", 32'(mulDivBusy), 32'd0);
    check("mflo_stallcount", 32'(stallCount), 32'd4);

    // ---- freeze for 3 cycles with a jump in the first ----
    do_reset();
    cyc('{default:'0, mem_wait:1'b1, jump:1'b1});
    check("frz_jump_c1", 32'(out8), 32'(O_FRZ));
    cyc('{default:'0, mem_wait:1'b1});
    check("frz_c2", 32'(out8), 32'(O_FRZ));
    cyc('{default:'0, mem_wait:1'b1});
    check("frz_c3", 32'(out8), 32'(O_FRZ));
    cyc('{default:'0});
    check("frz_pending_flush", 32'(out8), 32'(O_RUNF));
    check("frz_stallcount", 32'(stallCount), 32'd3);
    cyc('{default:'0});
    check("frz_flush_cleared", 32'(out8), 32'(O_RUN));

    // ---- counter saturation ----
    do_reset();
    @(negedge clk);
    drive('{default:'0, mem_wait:1'b1});
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    check("stallcount_sat", 32'(stallCount), 32'h0000_FFFF);

    // ---- reset in the middle of a mul/div (stallCount still saturated) ----
    cyc('{default:'0, ex_is_muldiv:1'b1});
    cyc('{default:'0, reads_hilo:1'b1});
    check("mid_mul_stall", 32'(out8), 32'(O_MUL));
    @(negedge clk);
    reset = 1'b1;
    drive('{default:'0, reads_hilo:1'b1, ex_is_muldiv:1'b1});
    #1;
    check("mid_reset_outputs", 32'(out8), 32'(O_RST));
    @(negedge clk);
    reset = 1'b0;
    drive('{default:'0, reads_hilo:1'b1});
    #1;
    check("post_reset_busy", 32'(mulDivBusy), 32'd0);
    check("post_reset_no_stall", 32'(out8), 32'(O_RUN));
    check("post_reset_stallcount", 32'(stallCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
